// File: rtl/spi_pwm_regs_pkg.sv
// Shared constants for the SPI-fed PWM register bank: address map, CTRL bit layout,
// and the prescaler terminal-count helper.
package spi_pwm_regs_pkg;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_DUTY   = 2'd1;
   localparam logic [1:0] ADDR_PERIOD = 2'd2;
   localparam logic [1:0] ADDR_COUNT  = 2'd3;

   localparam int EN_BIT    = 0;
   localparam int POL_BIT   = 1;
   localparam int PRESC_LSB = 2;
   localparam int PRESC_MSB = 3;

   localparam logic [7:0] RST_PERIOD_DEF = 8'hFF;

   // Terminal count of the prescaler: a tick every 2^presc clocks.
   function automatic logic [2:0] presc_mask(input logic [1:0] presc);
      logic [2:0] one;
      one = 3'd1;
      return (one << presc) - 3'd1;
   endfunction

endpackage

// File: rtl/spi_pwm_regs_if.sv
// SPI slave register port: SCLK-domain address/data/write level in, registered read data out.
interface spi_pwm_regs_if;
   logic [1:0] spi_addr;
   logic [7:0] spi_data_wr;
   logic       spi_wr_en;
   logic [7:0] spi_data_rd;

   modport master (output spi_addr, spi_data_wr, spi_wr_en, input spi_data_rd);
   modport slave  (input spi_addr, spi_data_wr, spi_wr_en, output spi_data_rd);
endinterface

// File: rtl/spi_pwm_regs_pwm_core.sv
// PWM engine: prescaler, 8-bit period counter, wrap-loaded shadow duty/period, registered output.
module spi_pwm_regs_pwm_core
   import spi_pwm_regs_pkg::*;
#(
   parameter logic [7:0] RST_PERIOD = RST_PERIOD_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       pol,
   input  logic [1:0] presc,
   input  logic [7:0] duty,
   input  logic [7:0] period,
   output logic [7:0] count,
   output logic       pwm_out,
   output logic       period_end
);

   logic [2:0] presc_cnt;
   logic [1:0] presc_act;
   logic [7:0] sh_duty;
   logic [7:0] sh_period;
   logic       tick;

   // presc_act is only reloaded when the prescaler clears, so a PRESC change never
   // strands presc_cnt above its terminal count.
   assign tick = en & (presc_cnt == presc_mask(presc_act));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_cnt  <= '0;
         presc_act  <= '0;
         count      <= '0;
         sh_duty    <= '0;
         sh_period  <= RST_PERIOD;
         period_end <= 1'b0;
      end else if (!en) begin
         presc_cnt  <= '0;
         presc_act  <= presc;
         count      <= '0;
         sh_duty    <= duty;
         sh_period  <= period;
         period_end <= 1'b0;
      end else begin
         period_end <= 1'b0;
         if (tick) begin
            presc_cnt <= '0;
            presc_act <= presc;
            if (count == sh_period) begin
               count      <= '0;
               sh_duty    <= duty;
               sh_period  <= period;
               period_end <= 1'b1;
            end else begin
               count <= count + 8'd1;
            end
         end else begin
            presc_cnt <= presc_cnt + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pwm_out <= 1'b0;
      else        pwm_out <= pol ^ (en & (count < sh_duty));
   end

endmodule

// File: rtl/spi_pwm_regs.sv
// System-clock register bank behind an SPI slave: synchronises the write level into a
// single write pulse, holds CTRL/DUTY/PERIOD, serves registered read data, drives the PWM.
module spi_pwm_regs
   import spi_pwm_regs_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] RST_PERIOD  = RST_PERIOD_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   spi_pwm_regs_if.slave  spi,
   output logic           pwm_out,
   output logic           period_end
);

   logic [SYNC_STAGES-1:0] wr_sync;
   logic                   wr_hist;
   logic                   wr_pulse;
   logic [3:0]             ctrl_q;
   logic [7:0]             duty_q;
   logic [7:0]             period_q;
   logic [7:0]             count;
   logic [7:0]             rd_mux;

   // spi_wr_en is a level from the SCLK domain; the edge detector turns each high level
   // into exactly one write, however long CS is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_sync <= '0;
         wr_hist <= 1'b0;
      end else begin
         wr_sync <= {wr_sync[SYNC_STAGES-2:0], spi.spi_wr_en};
         wr_hist <= wr_sync[SYNC_STAGES-1];
      end
   end

   assign wr_pulse = wr_sync[SYNC_STAGES-1] & ~wr_hist;

   // Address and data are quasi-static by the time the pulse appears, so they are
   // sampled directly; decoding only on wr_pulse keeps a dropped write harmless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q   <= '0;
         duty_q   <= '0;
         period_q <= RST_PERIOD;
      end else if (wr_pulse) begin
         case (spi.spi_addr)
            ADDR_CTRL:   ctrl_q   <= spi.spi_data_wr[3:0];
            ADDR_DUTY:   duty_q   <= spi.spi_data_wr;
            ADDR_PERIOD: period_q <= spi.spi_data_wr;
            default:     ;
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (spi.spi_addr)
         ADDR_CTRL:   rd_mux = {4'b0000, ctrl_q};
         ADDR_DUTY:   rd_mux = duty_q;
         ADDR_PERIOD: rd_mux = period_q;
         ADDR_COUNT:  rd_mux = count;
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) spi.spi_data_rd <= '0;
      else        spi.spi_data_rd <= rd_mux;
   end

   spi_pwm_regs_pwm_core #(
      .RST_PERIOD (RST_PERIOD)
   ) u_pwm_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (ctrl_q[EN_BIT]),
      .pol        (ctrl_q[POL_BIT]),
      .presc      (ctrl_q[PRESC_MSB:PRESC_LSB]),
      .duty       (duty_q),
      .period     (period_q),
      .count      (count),
      .pwm_out    (pwm_out),
      .period_end (period_end)
   );

endmodule
